// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix-ALU column sequencer.
package matrix_pkg;

    localparam int unsigned ROW_W     = 128;
    localparam int unsigned COL_W     = 32;
    localparam int unsigned N_ROWS    = 4;
    localparam int unsigned ROW_IDX_W = $clog2(N_ROWS);
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_MUL = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_CLEAR,
        ST_FINISH
    } state_t;

    // One memory word: four signed columns, col1 in the low bits.
    typedef struct packed {
        logic [COL_W-1:0] c4;
        logic [COL_W-1:0] c3;
        logic [COL_W-1:0] c2;
        logic [COL_W-1:0] c1;
    } row_t;

endpackage

// File: rtl/alu_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the ALU to answer.
module alu_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign expire_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Saturates at the expiry value so a stalled caller keeps seeing expire_c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count && !expire_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_alu_sequencer.sv
// Walks A and B row by row through the column ALU and writes each result row to C.
module matrix_alu_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Start,
    input  logic [2:0]         OpCode,
    input  logic [ADDR_W-1:0]  BaseA,
    input  logic [ADDR_W-1:0]  BaseB,
    input  logic [ADDR_W-1:0]  BaseC,
    output logic               Busy,
    output logic               Finished,
    output logic               ErrorFlag,
    output logic               MemRdEn,
    output logic [ADDR_W-1:0]  MemRdAddr,
    input  logic [127:0]       MemRdData,
    output logic               MemWrEn,
    output logic [ADDR_W-1:0]  MemWrAddr,
    output logic [127:0]       MemWrData,
    output logic [2:0]         Operation,
    output logic               ClearAll,
    output logic [31:0]        ColumnA1,
    output logic [31:0]        ColumnA2,
    output logic [31:0]        ColumnA3,
    output logic [31:0]        ColumnA4,
    output logic [31:0]        ColumnB1,
    output logic [31:0]        ColumnB2,
    output logic [31:0]        ColumnB3,
    output logic [31:0]        ColumnB4,
    input  logic               Done,
    input  logic               Error,
    input  logic [31:0]        NewColumn1,
    input  logic [31:0]        NewColumn2,
    input  logic [31:0]        NewColumn3,
    input  logic [31:0]        NewColumn4
);

    state_t                 state_q, state_d;
    logic [ROW_IDX_W-1:0]   row_q, row_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [ADDR_W-1:0]      base_a_q, base_a_d;
    logic [ADDR_W-1:0]      base_b_q, base_b_d;
    logic [ADDR_W-1:0]      base_c_q, base_c_d;
    logic                   err_q, err_d;
    logic                   abort_q, abort_d;
    row_t                   result_q, result_d;
    row_t                   col_a_q, col_a_d;
    row_t                   col_b_q, col_b_d;
    row_t                   rd_row;

    logic                   busy_q, busy_d;
    logic                   finished_q, finished_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [OP_W-1:0]        operation_q, operation_d;
    logic                   clear_q, clear_d;

    logic                   wd_load;
    logic                   wd_count;
    logic                   wd_expire_c;

    assign rd_row = MemRdData;

    alu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (Clock),
        .rst_n    (ResetN),
        .load     (wd_load),
        .count    (wd_count),
        .expire_c (wd_expire_c)
    );

    // Next-state, datapath capture and next-cycle output values.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        op_d        = op_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        base_c_d    = base_c_q;
        err_d       = err_q;
        abort_d     = abort_q;
        result_d    = result_q;
        col_a_d     = col_a_q;
        col_b_d     = col_b_q;
        wd_load     = 1'b0;
        wd_count    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d     = OpCode;
                    base_a_d = BaseA;
                    base_b_d = BaseB;
                    base_c_d = BaseC;
                    row_d    = '0;
                    abort_d  = 1'b0;
                    if (OpCode != OP_NOP) begin
                        err_d   = 1'b0;
                        state_d = ST_RD_A;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_RD_A: begin
                state_d = ST_RD_B;
            end
            ST_RD_B: begin
                col_a_d = rd_row;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                col_b_d = rd_row;
                wd_load = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_count = 1'b1;
                if (Error) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_CLEAR;
                end else if (Done) begin
                    result_d = '{c4: NewColumn4, c3: NewColumn3,
                                 c2: NewColumn2, c1: NewColumn1};
                    state_d  = ST_WRITE;
                end else if (wd_expire_c) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_WRITE: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (abort_q || (row_q == ROW_IDX_W'(N_ROWS - 1))) begin
                    state_d = ST_FINISH;
                end else begin
                    row_d   = row_q + ROW_IDX_W'(1);
                    state_d = ST_RD_A;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are flop-driven.
        busy_d      = (state_d != ST_IDLE);
        finished_d  = (state_d == ST_FINISH);
        rd_en_d     = (state_d == ST_RD_A) || (state_d == ST_RD_B);
        rd_addr_d   = '0;
        if (state_d == ST_RD_A) begin
            rd_addr_d = base_a_d + ADDR_W'(row_d);
        end else if (state_d == ST_RD_B) begin
            rd_addr_d = base_b_d + ADDR_W'(row_d);
        end
        wr_en_d     = (state_d == ST_WRITE);
        wr_addr_d   = (state_d == ST_WRITE) ? (base_c_d + ADDR_W'(row_d)) : '0;
        operation_d = (state_d == ST_WAIT) ? op_d : OP_NOP;
        clear_d     = (state_d == ST_CLEAR);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            op_q        <= OP_NOP;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            result_q    <= '0;
            col_a_q     <= '0;
            col_b_q     <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            operation_q <= OP_NOP;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            op_q        <= op_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_c_q    <= base_c_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            result_q    <= result_d;
            col_a_q     <= col_a_d;
            col_b_q     <= col_b_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            operation_q <= operation_d;
            clear_q     <= clear_d;
        end
    end

    assign Busy      = busy_q;
    assign Finished  = finished_q;
    assign ErrorFlag = err_q;
    assign MemRdEn   = rd_en_q;
    assign MemRdAddr = rd_addr_q;
    assign MemWrEn   = wr_en_q;
    assign MemWrAddr = wr_addr_q;
    assign MemWrData = result_q;
    assign Operation = operation_q;
    assign ClearAll  = clear_q;
    assign ColumnA1  = col_a_q.c1;
    assign ColumnA2  = col_a_q.c2;
    assign ColumnA3  = col_a_q.c3;
    assign ColumnA4  = col_a_q.c4;
    assign ColumnB1  = col_b_q.c1;
    assign ColumnB2  = col_b_q.c2;
    assign ColumnB3  = col_b_q.c3;
    assign ColumnB4  = col_b_q.c4;

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench: RAM model, element-wise multiply ALU responder and a write scoreboard.
module tb_matrix_alu_sequencer;

    logic         Clock;
    logic         ResetN;
    logic         Start;
    logic [2:0]   OpCode;
    logic [7:0]   BaseA, BaseB, BaseC;
    logic         Busy, Finished, ErrorFlag;
    logic         MemRdEn, MemWrEn;
    logic [7:0]   MemRdAddr, MemWrAddr;
    logic [127:0] MemRdData, MemWrData;
    logic [2:0]   Operation;
    logic         ClearAll;
    logic [31:0]  ColumnA1, ColumnA2, ColumnA3, ColumnA4;
    logic [31:0]  ColumnB1, ColumnB2, ColumnB3, ColumnB4;
    logic         Done, Error;
    logic [31:0]  NewColumn1, NewColumn2, NewColumn3, NewColumn4;

    matrix_alu_sequencer #(.ADDR_W(8), .TIMEOUT(64)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .OpCode(OpCode),
        .BaseA(BaseA), .BaseB(BaseB), .BaseC(BaseC),
        .Busy(Busy), .Finished(Finished), .ErrorFlag(ErrorFlag),
        .MemRdEn(MemRdEn), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
        .MemWrEn(MemWrEn), .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
        .Operation(Operation), .ClearAll(ClearAll),
        .ColumnA1(ColumnA1), .ColumnA2(ColumnA2), .ColumnA3(ColumnA3), .ColumnA4(ColumnA4),
        .ColumnB1(ColumnB1), .ColumnB2(ColumnB2), .ColumnB3(ColumnB3), .ColumnB4(ColumnB4),
        .Done(Done), .Error(Error),
        .NewColumn1(NewColumn1), .NewColumn2(NewColumn2),
        .NewColumn3(NewColumn3), .NewColumn4(NewColumn4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous-read RAM; contents are loaded once by the stimulus block.
    logic [127:0] mem [256];
    logic [127:0] rd_q;
    always @(posedge Clock) if (MemRdEn) rd_q <= mem[MemRdAddr];
    assign MemRdData = rd_q;

    // ALU responder: answers on the 4th WAIT cycle; mode 1 flags rows with col1=0xBAD, mode 2 never answers.
    int         alu_mode;
    logic [1:0] alu_cnt;
    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN)                alu_cnt <= 2'd0;
        else if (Operation != 3'd0) alu_cnt <= alu_cnt + 2'd1;
        else                        alu_cnt <= 2'd0;
    end
    assign Done  = (alu_mode != 2) && (Operation != 3'd0) && (alu_cnt == 2'd3);
    assign Error = (alu_mode == 1) && (Operation != 3'd0) && (alu_cnt == 2'd3) &&
                   (ColumnA1 == 32'h0000_0BAD);
    assign NewColumn1 = 32'($signed(ColumnA1) * $signed(ColumnB1));
    assign NewColumn2 = 32'($signed(ColumnA2) * $signed(ColumnB2));
    assign NewColumn3 = 32'($signed(ColumnA3) * $signed(ColumnB3));
    assign NewColumn4 = 32'($signed(ColumnA4) * $signed(ColumnB4));

    // Event counters and write scoreboard, sampled mid-cycle.
    typedef struct packed {
        logic [7:0]   addr;
        logic [127:0] data;
    } wr_t;
    wr_t sb[$];
    int fin_cnt = 0, rd_cnt = 0, wr_cnt = 0, op_cnt = 0, clr_cnt = 0;

    always @(negedge Clock) begin
        if (ResetN) begin
            if (Finished)          fin_cnt++;
            if (MemRdEn)           rd_cnt++;
            if (Operation != 3'd0) op_cnt++;
            if (ClearAll)          clr_cnt++;
            if (MemWrEn) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 128'(MemWrAddr), 128'hFFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 128'(MemWrAddr), 128'(e.addr));
                    check("wr_data", MemWrData, e.data);
                end
            end
        end
    end

    function automatic logic [127:0] row4(input int v);
        return {4{32'(v)}};
    endfunction

    task automatic push_exp(input logic [7:0] a, input int v);
        wr_t e;
        e.addr = a;
        e.data = row4(v);
        sb.push_back(e);
    endtask

    // Leaves time at 1ns after the edge that sampled Start (first busy cycle).
    task automatic start_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
        @(posedge Clock); #1;
        OpCode = op; BaseA = a; BaseB = b; BaseC = c; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
    endtask

    task automatic wait_finish(input int limit, output int n);
        n = 1;
        while (!Finished && n < limit) begin
            @(posedge Clock); #1;
            n++;
        end
        check("finished_seen", 128'(Finished), 128'(1));
    endtask

    int n;
    int f0, r0, w0, o0, c0;

    initial begin
        ResetN = 1'b0; Start = 1'b0; OpCode = 3'd0;
        BaseA = 8'd0; BaseB = 8'd0; BaseC = 8'd0; alu_mode = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int r = 0; r < 4; r++) begin
            mem[8'h10 + r] = row4(4);
            mem[8'h20 + r] = row4((r % 2 == 0) ? -5 : 5);
            mem[8'h30 + r] = row4(4);
        end
        mem[8'h32] = {32'd4, 32'd4, 32'd4, 32'h0000_0BAD};

        // Reset state
        #12;
        check("rst_ctrl", 128'({Busy, Finished, ErrorFlag, MemRdEn, MemWrEn, ClearAll, Operation}), 128'(0));
        check("rst_addr", 128'({MemRdAddr, MemWrAddr}), 128'(0));
        check("rst_cola", {ColumnA4, ColumnA3, ColumnA2, ColumnA1}, 128'(0));
        check("rst_colb", {ColumnB4, ColumnB3, ColumnB2, ColumnB1}, 128'(0));
        #10 ResetN = 1'b1;

        // 1: full multiply run
        for (int r = 0; r < 4; r++) push_exp(8'h40 + 8'(r), (r % 2 == 0) ? -20 : 20);
        f0 = fin_cnt;
        start_op(3'b001, 8'h10, 8'h20, 8'h40);
        check("t1_busy", 128'(Busy), 128'(1));
        wait_finish(200, n);
        check("t1_latency", 128'(n), 128'(37));
        check("t1_errflag", 128'(ErrorFlag), 128'(0));
        repeat (3) @(posedge Clock);
        #1;
        check("t1_busy_low", 128'(Busy), 128'(0));
        check("t1_fin_count", 128'(fin_cnt - f0), 128'(1));
        check("t1_sb_empty", 128'(sb.size()), 128'(0));

        // 2: NOP opcode is rejected
        f0 = fin_cnt; r0 = rd_cnt; w0 = wr_cnt; o0 = op_cnt;
        start_op(3'b000, 8'h10, 8'h20, 8'h40);
        wait_finish(10, n);
        check("t2_latency", 128'(n), 128'(1));
        check("t2_errflag", 128'(ErrorFlag), 128'(1));
        repeat (3) @(posedge Clock);
        #1;
        check("t2_fin_count", 128'(fin_cnt - f0), 128'(1));
        check("t2_no_rd", 128'(rd_cnt - r0), 128'(0));
        check("t2_no_wr", 128'(wr_cnt - w0), 128'(0));
        check("t2_no_op", 128'(op_cnt - o0), 128'(0));

        // 3: ALU Error on row 2 (also raised with Done; Error wins)
        alu_mode = 1;
        push_exp(8'h50, -20);
        push_exp(8'h51, 20);
        w0 = wr_cnt; c0 = clr_cnt;
        start_op(3'b001, 8'h30, 8'h20, 8'h50);
        check("t3_errflag_clr", 128'(ErrorFlag), 128'(0));
        wait_finish(200, n);
        check("t3_latency", 128'(n), 128'(27));
        check("t3_errflag", 128'(ErrorFlag), 128'(1));
        repeat (2) @(posedge Clock);
        #1;
        check("t3_writes", 128'(wr_cnt - w0), 128'(2));
        check("t3_clears", 128'(clr_cnt - c0), 128'(3));
        check("t3_sb_empty", 128'(sb.size()), 128'(0));

        // 4: ALU never answers -> timeout
        alu_mode = 2;
        w0 = wr_cnt; o0 = op_cnt;
        start_op(3'b010, 8'h10, 8'h20, 8'h60);
        check("t4_errflag_clr", 128'(ErrorFlag), 128'(0));
        wait_finish(300, n);
        check("t4_latency", 128'(n), 128'(69));
        check("t4_wait_cycles", 128'(op_cnt - o0), 128'(64));
        check("t4_no_wr", 128'(wr_cnt - w0), 128'(0));
        check("t4_errflag", 128'(ErrorFlag), 128'(1));

        // 5: reset during row 1 WAIT
        alu_mode = 0;
        push_exp(8'h70, -20);
        start_op(3'b001, 8'h10, 8'h20, 8'h70);
        repeat (13) @(posedge Clock);
        #1;
        check("t5_in_wait", 128'(Operation), 128'(3'b001));
        #2 ResetN = 1'b0;
        #1;
        check("t5_rst_ctrl", 128'({Busy, Finished, ErrorFlag, MemRdEn, MemWrEn, ClearAll, Operation}), 128'(0));
        check("t5_rst_cola", {ColumnA4, ColumnA3, ColumnA2, ColumnA1}, 128'(0));
        check("t5_rst_colb", {ColumnB4, ColumnB3, ColumnB2, ColumnB1}, 128'(0));
        check("t5_sb_empty", 128'(sb.size()), 128'(0));
        repeat (2) @(posedge Clock);
        #3 ResetN = 1'b1;

        // 6: C base wraps; Start while busy is ignored
        for (int r = 0; r < 4; r++) push_exp(8'hFE + 8'(r), (r % 2 == 0) ? -20 : 20);
        f0 = fin_cnt;
        start_op(3'b001, 8'h10, 8'h20, 8'hFE);
        repeat (5) @(posedge Clock);
        #1;
        Start = 1'b1; OpCode = 3'b000;
        @(posedge Clock); #1;
        Start = 1'b0; OpCode = 3'b001;
        wait_finish(200, n);
        check("t6_errflag", 128'(ErrorFlag), 128'(0));
        repeat (4) @(posedge Clock);
        #1;
        check("t6_fin_count", 128'(fin_cnt - f0), 128'(1));
        check("t6_busy_low", 128'(Busy), 128'(0));
        check("t6_sb_empty", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
